// File: rtl/memory_access_ctrl.sv
// Stalling controller for a multi-cycle data memory: issues one load/store per instruction.
// Optional alignment check enabled by defining MEM_ALIGN_CHK_EN.
module memory_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ALU_result_in,
  input  logic [15:0] write_data_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  input  logic        mem_done,
  input  logic [15:0] mem_rdata,
  output logic [15:0] read_data_out,
  output logic        stall_out,
  output logic        align_err
);

  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        r_state;
  logic          r_mem_req;
  logic [DW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_wr;
  logic [DW-1:0] r_read_data;
  logic          r_align_err;

  logic w_req;
  logic w_misaligned;
  logic w_issue;
  logic w_stall;

  assign w_req = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHK_EN
  assign w_misaligned = ALU_result_in[0];
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_issue = w_req & ~w_misaligned;

  // Single FSM process; a simultaneous read+write request is issued as a store.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_wr    <= 1'b0;
      r_read_data <= '0;
      r_align_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_mem_addr  <= ALU_result_in;
            r_mem_wdata <= write_data_in;
            r_mem_wr    <= mem_write_in;
            r_mem_req   <= 1'b1;
            r_state     <= BUSY;
          end else if (w_req && w_misaligned) begin
            r_align_err <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_done) begin
            if (!r_mem_wr) begin
              r_read_data <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  // Stall is combinational so the upstream stage freezes in the same cycle a request appears.
  always_comb begin
    w_stall = 1'b0;
    if (rst) begin
      case (r_state)
        IDLE:    w_stall = w_issue;
        BUSY:    w_stall = 1'b1;
        default: w_stall = 1'b0;
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign mem_wr        = r_mem_wr;
  assign read_data_out = r_read_data;
  assign stall_out     = w_stall;
  assign align_err     = r_align_err;

endmodule

// File: doc/memory_access_ctrl.md
MEMORY_ACCESS_CTRL -- requirements
Module: memory_access_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous reset, active-low (rst=0 at a rising edge resets).
REQ-003 SHALL provide: ALU_result_in  in  16  memory address from execute/memory register.
REQ-004 SHALL provide: write_data_in  in  16  store data.
REQ-005 SHALL provide: mem_read_in / mem_write_in  in  1 each  load / store request for current instruction.
REQ-006 SHALL provide: mem_req  out  1  request to multi-cycle data memory, registered.
REQ-007 SHALL provide: mem_addr / mem_wdata  out  16 each  latched address / store data, registered.
REQ-008 SHALL provide: mem_wr  out  1  1=store, 0=load, registered.
REQ-009 SHALL provide: mem_done  in  1  one-cycle completion pulse from memory.
REQ-010 SHALL provide: mem_rdata  in  16  load data, valid when mem_done=1.
REQ-011 SHALL provide: read_data_out  out  16  captured load data feeding memory/writeback register.
REQ-012 SHALL provide: stall_out  out  1  freezes upstream pipeline registers.
REQ-013 SHALL provide: align_err  out  1  sticky misaligned-access flag (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-015 IDLE with mem_read_in|mem_write_in=1 SHALL latch address, store data, direction; next state BUSY.
REQ-016 IDLE with no request SHALL remain IDLE; mem_req=0.
REQ-017 BUSY SHALL hold mem_req=1 with mem_addr/mem_wdata/mem_wr stable until mem_done sampled 1.
REQ-018 BUSY with mem_done=1 SHALL capture mem_rdata into read_data_out (loads only), drop mem_req, go to DONE.
REQ-019 Stores SHALL leave read_data_out unchanged.
REQ-020 DONE SHALL go unconditionally to IDLE; no new request issued in DONE (same instruction still presented).
REQ-021 stall_out SHALL be combinational: 1 in IDLE with a request pending, 1 in BUSY, 0 in DONE and idle IDLE.
REQ-022 Minimum latency per access SHALL be 3 cycles (IDLE issue, BUSY, DONE); each extra BUSY cycle adds one.
REQ-023 mem_read_in and mem_write_in both 1 SHALL be treated as store; load ignored.
REQ-024 mem_done outside BUSY SHALL be ignored.
REQ-025 Back-to-back accesses SHALL each pass through DONE; no request overlap.

Reset
REQ-026 rst=0 SHALL force IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, read_data_out=0, align_err=0.
REQ-027 Reset during BUSY SHALL abandon the access; mem_req=0 after that edge; later mem_done ignored.
REQ-028 stall_out SHALL be 0 while rst=0.

Configuration
REQ-029 Macro MEM_ALIGN_CHK_EN SHALL control alignment checking.
REQ-030 Defined: request in IDLE with ALU_result_in[0]=1 SHALL set align_err (sticky until reset), issue no request, stall_out=0, stay IDLE.
REQ-031 Not defined: align_err tied 0; odd addresses issued unchanged.

Verification
REQ-032 Load 0x0010, mem_done 2 cycles after mem_req rises, mem_rdata=0xBEEF -> read_data_out=0xBEEF in DONE; stall_out high 3 cycles.
REQ-033 Store 0x0020 data 0x1234, mem_done after 1 BUSY cycle -> mem_wr=1, mem_wdata=0x1234 stable while mem_req=1; read_data_out unchanged.
REQ-034 mem_read_in=mem_write_in=1, addr 0x0004 -> store issued (mem_wr=1), no read_data_out update.
REQ-035 rst=0 in BUSY, then mem_done pulse -> IDLE, mem_req=0, read_data_out=0000, stall_out=0.
REQ-036 MEM_ALIGN_CHK_EN defined, load 0x0003 -> align_err=1, mem_req stays 0; undefined -> mem_addr=0x0003 issued.
REQ-037 Two loads back-to-back (0x0002 then 0x0006) -> two distinct mem_req windows separated by DONE cycle, correct data each.
